// File: rtl/datapath_unit.sv
// CPU datapath: PC, IR, 16x16 register file, ALU and 256x16 synchronous data memory.
// Executes the control unit's command signals and hands IR back to it.
module datapath_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PC_CLR,
  input  logic        PC_IC,
  input  logic        IR_LD,
  input  logic [7:0]  D_ADDR,
  input  logic        D_WR,
  input  logic        RF_S,
  input  logic        RF_W_EN,
  input  logic [3:0]  RF_A_ADDR,
  input  logic [3:0]  RF_B_ADDR,
  input  logic [3:0]  RF_W_ADDR,
  input  logic [3:0]  ALU_S,
  input  logic [15:0] I_DATA,
  output logic [7:0]  I_ADDR,
  output logic [15:0] IR,
  output logic [15:0] ALU_Out,
  output logic        ALU_Z,
  output logic        ALU_N
);

  localparam logic [3:0] ALU_PASS = 4'h0, ALU_ADD = 4'h1, ALU_SUB = 4'h2,
                         ALU_AND  = 4'h3, ALU_OR  = 4'h4, ALU_XOR = 4'h5,
                         ALU_NAND = 4'h6, ALU_SHL = 4'h7, ALU_SHR = 4'h8,
                         ALU_ROL  = 4'h9, ALU_ROR = 4'hA;

  logic [7:0]  pc;
  logic [15:0] rf [16];
  logic [15:0] mem [256];
  logic [15:0] d_rdata;
  logic [15:0] a_data, b_data, w_data;
  logic [3:0]  sh;
  logic [4:0]  rsh;

  assign I_ADDR = pc;
  assign a_data = rf[RF_A_ADDR];
  assign b_data = rf[RF_B_ADDR];
  assign w_data = RF_S ? d_rdata : ALU_Out;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)       pc <= '0;
    else if (PC_CLR) pc <= '0;
    else if (PC_IC)  pc <= pc + 8'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)      IR <= '0;
    else if (IR_LD) IR <= I_DATA;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (RF_W_EN) begin
      rf[RF_W_ADDR] <= w_data;
    end
  end

  // Array contents survive reset; only the write is suppressed while Reset is high.
  always_ff @(posedge Clock) begin
    if (!Reset && D_WR) mem[D_ADDR] <= a_data;
  end

  // Registered read returns pre-write contents on a same-address write.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) d_rdata <= '0;
    else       d_rdata <= mem[D_ADDR];
  end

  assign sh  = b_data[3:0];
  assign rsh = 5'd16 - {1'b0, sh};

  always_comb begin
    ALU_Out = '0;
    case (ALU_S)
      ALU_PASS: ALU_Out = a_data;
      ALU_ADD:  ALU_Out = a_data + b_data;
      ALU_SUB:  ALU_Out = a_data - b_data;
      ALU_AND:  ALU_Out = a_data & b_data;
      ALU_OR:   ALU_Out = a_data | b_data;
      ALU_XOR:  ALU_Out = a_data ^ b_data;
      ALU_NAND: ALU_Out = ~(a_data & b_data);
      ALU_SHL:  ALU_Out = a_data << sh;
      ALU_SHR:  ALU_Out = a_data >> sh;
      // A shift by 16 yields zero, so sh = 0 degenerates to a plain pass.
      ALU_ROL:  ALU_Out = (a_data << sh) | (a_data >> rsh);
      ALU_ROR:  ALU_Out = (a_data >> sh) | (a_data << rsh);
      default:  ALU_Out = '0;
    endcase
  end

  assign ALU_Z = (ALU_Out == 16'h0000);
  assign ALU_N = ALU_Out[15];

endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: ALU vector table plus hand sequences for PC, IR,
// reset, load/store and same-cycle conflicts, checked through a scoreboard queue.
module tb_datapath_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        PC_CLR = 0, PC_IC = 0, IR_LD = 0, D_WR = 0, RF_S = 0, RF_W_EN = 0;
  logic [7:0]  D_ADDR = '0;
  logic [3:0]  RF_A_ADDR = '0, RF_B_ADDR = '0, RF_W_ADDR = '0, ALU_S = '0;
  logic [15:0] I_DATA = '0;
  logic [7:0]  I_ADDR;
  logic [15:0] IR, ALU_Out;
  logic        ALU_Z, ALU_N;

  always #5 Clock = ~Clock;

  datapath_unit dut (
    .Clock(Clock), .Reset(Reset), .PC_CLR(PC_CLR), .PC_IC(PC_IC), .IR_LD(IR_LD),
    .D_ADDR(D_ADDR), .D_WR(D_WR), .RF_S(RF_S), .RF_W_EN(RF_W_EN),
    .RF_A_ADDR(RF_A_ADDR), .RF_B_ADDR(RF_B_ADDR), .RF_W_ADDR(RF_W_ADDR),
    .ALU_S(ALU_S), .I_DATA(I_DATA), .I_ADDR(I_ADDR), .IR(IR),
    .ALU_Out(ALU_Out), .ALU_Z(ALU_Z), .ALU_N(ALU_N)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { string name; logic [15:0] exp; } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [3:0]  s;
    logic [15:0] a, b, exp;
    logic        z, n;
  } vec_t;
  vec_t tbl [19];

  task automatic sb_exp(input string n, input logic [15:0] e);
    sb_t t;
    t.name = n; t.exp = e;
    sbq.push_back(t);
  endtask

  task automatic sb_obs(input logic [15:0] act);
    sb_t t;
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: observed %h with nothing expected", act);
    end else begin
      t = sbq.pop_front();
      if (act !== t.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", t.name, act, t.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic rf_op(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] w);
    ALU_S = s; RF_A_ADDR = a; RF_B_ADDR = b; RF_W_ADDR = w; RF_S = 0; RF_W_EN = 1;
    tick();
    RF_W_EN = 0;
  endtask

  // Builds a constant in register r by shift/add, using R15 = 0001.
  task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
    rf_op(4'h2, r, r, r);
    for (int i = 15; i >= 0; i--) begin
      rf_op(4'h7, r, 4'd15, r);
      if (v[i]) rf_op(4'h1, r, 4'd15, r);
    end
  endtask

  task automatic chk_reg(input string n, input logic [3:0] r, input logic [15:0] e);
    sb_exp(n, e);
    RF_A_ADDR = r; ALU_S = 4'h0;
    #1;
    sb_obs(ALU_Out);
  endtask

  task automatic chk_pc(input string n, input logic [7:0] e);
    sb_exp(n, {8'h00, e});
    sb_obs({8'h00, I_ADDR});
  endtask

  task automatic init_one();
    rf_op(4'h2, 4'd15, 4'd15, 4'd15);
    rf_op(4'h6, 4'd15, 4'd15, 4'd15);
    rf_op(4'h8, 4'd15, 4'd15, 4'd15);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'h0, 16'h1234, 16'h5678, 16'h1234, 1'b0, 1'b0};
    tbl[1]  = '{4'h1, 16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b0};
    tbl[2]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{4'h2, 16'h0001, 16'hFFFF, 16'h0002, 1'b0, 1'b0};
    tbl[4]  = '{4'h2, 16'h1234, 16'h5678, 16'hBBBC, 1'b0, 1'b1};
    tbl[5]  = '{4'h3, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    tbl[6]  = '{4'h4, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b1};
    tbl[7]  = '{4'h5, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b1};
    tbl[8]  = '{4'h6, 16'hF0F0, 16'h3C3C, 16'hCFCF, 1'b0, 1'b1};
    tbl[9]  = '{4'h7, 16'h8001, 16'h0004, 16'h0010, 1'b0, 1'b0};
    tbl[10] = '{4'h7, 16'h1234, 16'h0013, 16'h91A0, 1'b0, 1'b1};
    tbl[11] = '{4'h8, 16'h8001, 16'h0004, 16'h0800, 1'b0, 1'b0};
    tbl[12] = '{4'h8, 16'h8001, 16'hFFFF, 16'h0001, 1'b0, 1'b0};
    tbl[13] = '{4'h9, 16'h8001, 16'h0004, 16'h0018, 1'b0, 1'b0};
    tbl[14] = '{4'h9, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0};
    tbl[15] = '{4'hA, 16'h8001, 16'h0004, 16'h1800, 1'b0, 1'b0};
    tbl[16] = '{4'hA, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0};
    tbl[17] = '{4'hB, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0};
    tbl[18] = '{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0};

    // Reset state at power-up
    #3;
    chk_pc("pc_por", 8'h00);
    sb_exp("ir_por", 16'h0000); sb_obs(IR);
    tick();
    Reset = 0;

    // Async reset between edges with PC = 37, IR = ABCD
    PC_CLR = 1; tick(); PC_CLR = 0;
    PC_IC = 1; repeat (8'h37) tick(); PC_IC = 0;
    I_DATA = 16'hABCD; IR_LD = 1; tick(); IR_LD = 0;
    rf_op(4'h6, 4'd15, 4'd15, 4'd15);
    chk_pc("pc_pre_reset", 8'h37);
    sb_exp("ir_pre_reset", 16'hABCD); sb_obs(IR);
    chk_reg("r15_pre_reset", 4'd15, 16'hFFFF);
    #1 Reset = 1;
    #1;
    chk_pc("pc_async_reset", 8'h00);
    sb_exp("ir_async_reset", 16'h0000); sb_obs(IR);
    for (int r = 0; r < 16; r++) chk_reg($sformatf("rf_reset_r%0d", r), r[3:0], 16'h0000);
    @(posedge Clock); #1 Reset = 0;
    PC_IC = 1; repeat (3) tick(); PC_IC = 0;
    chk_pc("pc_after_3_inc", 8'h03);

    // PC priority and wrap
    PC_CLR = 1; PC_IC = 1; tick(); PC_CLR = 0; PC_IC = 0;
    chk_pc("pc_clr_priority", 8'h00);
    PC_IC = 1; repeat (255) tick();
    chk_pc("pc_ff", 8'hFF);
    tick(); PC_IC = 0;
    chk_pc("pc_wrap", 8'h00);

    // Fetch
    I_DATA = 16'h1234; IR_LD = 1; tick(); IR_LD = 0;
    sb_exp("ir_load", 16'h1234); sb_obs(IR);
    I_DATA = 16'h5555; tick();
    sb_exp("ir_hold", 16'h1234); sb_obs(IR);

    init_one();
    chk_reg("r15_one", 4'd15, 16'h0001);

    // ALU vector table
    for (int i = 0; i < 19; i++) begin
      set_reg(4'd1, tbl[i].a);
      set_reg(4'd2, tbl[i].b);
      ALU_S = tbl[i].s; RF_A_ADDR = 4'd1; RF_B_ADDR = 4'd2;
      sb_exp($sformatf("alu_out[%0d]", i), tbl[i].exp);
      sb_exp($sformatf("alu_zn[%0d]", i), {14'h0, tbl[i].z, tbl[i].n});
      #1;
      sb_obs(ALU_Out);
      sb_obs({14'h0, ALU_Z, ALU_N});
    end

    // Store then load
    set_reg(4'd3, 16'hBEEF);
    D_ADDR = 8'h42; RF_A_ADDR = 4'd3; D_WR = 1; tick(); D_WR = 0;
    tick();
    RF_S = 1; RF_W_EN = 1; RF_W_ADDR = 4'd7; tick(); RF_W_EN = 0; RF_S = 0;
    chk_reg("load_r7", 4'd7, 16'hBEEF);

    // ALU write-back
    set_reg(4'd1, 16'hFFFF); set_reg(4'd2, 16'h0001); set_reg(4'd4, 16'h5A5A);
    ALU_S = 4'h1; RF_A_ADDR = 4'd1; RF_B_ADDR = 4'd2; #1;
    sb_exp("add_out", 16'h0000); sb_obs(ALU_Out);
    sb_exp("add_zn", 16'h0002); sb_obs({14'h0, ALU_Z, ALU_N});
    RF_W_ADDR = 4'd4; RF_S = 0; RF_W_EN = 1; tick(); RF_W_EN = 0;
    chk_reg("add_r4", 4'd4, 16'h0000);
    ALU_S = 4'h2; RF_A_ADDR = 4'd2; RF_B_ADDR = 4'd1; #1;
    sb_exp("sub_out", 16'h0002); sb_obs(ALU_Out);
    sb_exp("sub_n", 16'h0000); sb_obs({15'h0, ALU_N});

    // RF write and read of same register in one cycle
    set_reg(4'd5, 16'h2222); set_reg(4'd6, 16'h1111);
    D_ADDR = 8'h20; RF_A_ADDR = 4'd6; D_WR = 1; tick(); D_WR = 0;
    tick();
    RF_S = 1; RF_W_EN = 1; RF_W_ADDR = 4'd5; RF_A_ADDR = 4'd5; ALU_S = 4'h0; #1;
    sb_exp("rf_rdw_old", 16'h2222); sb_obs(ALU_Out);
    tick(); RF_W_EN = 0; RF_S = 0;
    sb_exp("rf_rdw_new", 16'h1111); sb_obs(ALU_Out);

    // Memory read during write to the same address
    D_ADDR = 8'h10; RF_A_ADDR = 4'd6; D_WR = 1; tick(); D_WR = 0;
    set_reg(4'd6, 16'h3333);
    D_ADDR = 8'h10; RF_A_ADDR = 4'd6; D_WR = 1; tick(); D_WR = 0;
    RF_S = 1; RF_W_EN = 1; RF_W_ADDR = 4'd8; tick();
    RF_W_ADDR = 4'd9; tick();
    // D_WR together with a memory-sourced register write
    RF_A_ADDR = 4'd5; D_WR = 1; RF_W_ADDR = 4'd10; tick(); D_WR = 0;
    RF_W_ADDR = 4'd11; tick();
    RF_W_ADDR = 4'd12; tick();
    RF_W_EN = 0; RF_S = 0;
    chk_reg("mem_rdw_old", 4'd8, 16'h1111);
    chk_reg("mem_rdw_new", 4'd9, 16'h3333);
    chk_reg("wr_and_load_reg", 4'd10, 16'h3333);
    chk_reg("wr_and_load_mem", 4'd12, 16'h1111);

    // Reset blocks memory and register writes
    Reset = 1;
    D_ADDR = 8'h10; RF_A_ADDR = 4'd0; D_WR = 1;
    ALU_S = 4'h6; RF_B_ADDR = 4'd0; RF_S = 0; RF_W_ADDR = 4'd4; RF_W_EN = 1;
    repeat (2) @(posedge Clock);
    #1;
    D_WR = 0; RF_W_EN = 0; Reset = 0;
    chk_reg("rf_no_write_in_reset", 4'd4, 16'h0000);
    tick();
    RF_S = 1; RF_W_EN = 1; RF_W_ADDR = 4'd3; tick(); RF_W_EN = 0; RF_S = 0;
    chk_reg("mem_kept_in_reset", 4'd3, 16'h1111);

    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_leftover: %0d expected entries never observed, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
